// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/write-back sequencing.
// Optional ADDI support is compiled in when the CTRL_ADDI_EN macro is defined.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12,
        TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    assign state = STATE_W'(state_q);

    // Memory handshake: an access is held in FETCH/MEM_READ/MEM_WRITE with its strobes
    // asserted; the cycle in which mem_ready=1 completes it and the FSM leaves the state.
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      state_d = ADDI_EXEC;
`endif
                    default:      state_d = TRAP;
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW)      state_d = MEM_READ;
                else if (opcode == OP_SW) state_d = MEM_WRITE;
                else                      state_d = TRAP;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = FETCH;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = R_WB;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = FETCH;
            end
`ifdef CTRL_ADDI_EN
            ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
`endif
            TRAP: illegal = 1'b1;
            // Unused encodings fall into the trap; only reset leaves it.
            default: state_d = TRAP;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction state/output plans versus the DUT, cycle counts,
// stalls, traps and asynchronous reset.
module tb_multicycle_control;
    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MA = 4'd3;
    localparam logic [3:0] S_MR = 4'd4, S_MWB = 4'd5, S_MW = 4'd6, S_EX = 4'd7, S_RWB = 4'd8;
    localparam logic [3:0] S_BR = 4'd9, S_J = 4'd10, S_AE = 4'd11, S_AW = 4'd12, S_TRAP = 4'd15;

    typedef struct packed {
        logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst;
        logic [1:0] aluop, alusrcb, pcsource;
        logic       illegal;
    } outs_t;

    logic clk = 1'b0;
    logic reset_n;
    logic [5:0] opcode;
    logic mem_ready;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, illegal;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic [3:0] state;
    outs_t outs;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];  // {state, mem_ready, opcode} per cycle

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .illegal(illegal), .state(state)
    );

    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
                   RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, illegal};

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Datapath controls expected in each state, straight from the state descriptions.
    function automatic outs_t exp_outs(input logic [3:0] st, input logic mr);
        outs_t o = '0;
        case (st)
            S_FETCH:  begin o.memread = 1; o.alusrcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
            S_DECODE: o.alusrcb = 2'b11;
            S_MA:     begin o.alusrca = 1; o.alusrcb = 2'b10; end
            S_MR:     begin o.memread = 1; o.iord = 1; end
            S_MWB:    begin o.regwrite = 1; o.memtoreg = 1; end
            S_MW:     begin o.memwrite = 1; o.iord = 1; end
            S_EX:     begin o.alusrca = 1; o.aluop = 2'b10; end
            S_RWB:    begin o.regwrite = 1; o.regdst = 1; end
            S_BR:     begin o.alusrca = 1; o.aluop = 2'b01; o.pcwritecond = 1; o.pcsource = 2'b01; end
            S_J:      begin o.pcwrite = 1; o.pcsource = 2'b10; end
            S_AE:     begin o.alusrca = 1; o.alusrcb = 2'b10; end
            S_AW:     o.regwrite = 1;
            S_TRAP:   o.illegal = 1;
            default:  o = '0;
        endcase
        return o;
    endfunction

    function automatic bit addi_enabled();
`ifdef CTRL_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Cycles from FETCH to the next FETCH with mem_ready held high.
    function automatic int cpi(input logic [5:0] op);
        case (op)
            6'd0: return 4;
            6'd35: return 5;
            6'd43: return 4;
            6'd4, 6'd2: return 3;
            6'd8: return 4;
            default: return -1;
        endcase
    endfunction

    // driver tasks
    task automatic drive_cycle(input logic mr, input logic [5:0] op);
        @(negedge clk);
        mem_ready = mr;
        opcode = op;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic push_plain(input logic [3:0] st, input logic [5:0] op);
        exp_q.push_back({st, 1'($urandom_range(0, 1)), op});
    endtask

    task automatic push_access(input logic [3:0] st, input logic [5:0] op, input int stalls, input bit rand_op);
        for (int k = 0; k < stalls; k++) exp_q.push_back({st, 1'b0, rand_op ? 6'($urandom) : op});
        exp_q.push_back({st, 1'b1, rand_op ? 6'($urandom) : op});
    endtask

    // Expected per-cycle state path of one instruction; opcode is random while fetching.
    task automatic plan_instr(input logic [5:0] op, input int sf, input int sm);
        push_access(S_FETCH, op, sf, 1'b1);
        push_plain(S_DECODE, op);
        case (op)
            6'd0: begin push_plain(S_EX, op); push_plain(S_RWB, op); end
            6'd35: begin push_plain(S_MA, op); push_access(S_MR, op, sm, 1'b0); push_plain(S_MWB, op); end
            6'd43: begin push_plain(S_MA, op); push_access(S_MW, op, sm, 1'b0); end
            6'd4: push_plain(S_BR, op);
            6'd2: push_plain(S_J, op);
            6'd8: if (addi_enabled()) begin push_plain(S_AE, op); push_plain(S_AW, op); end
                  else push_plain(S_TRAP, op);
            default: push_plain(S_TRAP, op);
        endcase
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'd35;
        #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_release_idle: got %0d want %0d", state, S_IDLE); end
        drive_cycle(1'b0, 6'd0);
        checks++; if (state !== S_FETCH) begin errors++; $display("FAIL reset_first_fetch: got %0d want %0d", state, S_FETCH); end
        checks++; if (outs !== exp_outs(S_FETCH, 1'b0)) begin errors++; $display("FAIL reset_fetch_outs: got %h want %h", outs, exp_outs(S_FETCH, 1'b0)); end
    endtask

    task automatic test_lw();
        logic [10:0] e;
        do_reset();
        plan_instr(6'd35, 0, 0);
        plan_instr(6'd35, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_cycle(e[6], e[5:0]);
            checks++; if (state !== e[10:7]) begin errors++; $display("FAIL lw_state: got %0d want %0d", state, e[10:7]); end
            checks++; if (outs !== exp_outs(e[10:7], e[6])) begin errors++; $display("FAIL lw_outs st%0d: got %h want %h", e[10:7], outs, exp_outs(e[10:7], e[6])); end
        end
    endtask

    task automatic test_rtype_branch_jump();
        logic [10:0] e;
        do_reset();
        plan_instr(6'd0, 0, 0);
        plan_instr(6'd4, 1, 0);
        plan_instr(6'd2, 0, 0);
        plan_instr(6'd0, 2, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_cycle(e[6], e[5:0]);
            checks++; if (state !== e[10:7]) begin errors++; $display("FAIL rbj_state: got %0d want %0d", state, e[10:7]); end
            checks++; if (outs !== exp_outs(e[10:7], e[6])) begin errors++; $display("FAIL rbj_outs st%0d: got %h want %h", e[10:7], outs, exp_outs(e[10:7], e[6])); end
        end
    endtask

    task automatic test_sw_stall();
        logic [10:0] e;
        int memwrite_cycles = 0;
        do_reset();
        plan_instr(6'd43, 2, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_cycle(e[6], e[5:0]);
            if (MemWrite === 1'b1) memwrite_cycles++;
            checks++; if (state !== e[10:7]) begin errors++; $display("FAIL sw_state: got %0d want %0d", state, e[10:7]); end
            checks++; if (outs !== exp_outs(e[10:7], e[6])) begin errors++; $display("FAIL sw_outs st%0d: got %h want %h", e[10:7], outs, exp_outs(e[10:7], e[6])); end
        end
        drive_cycle(1'b0, 6'd0);
        checks++; if (state !== S_FETCH) begin errors++; $display("FAIL sw_return: got %0d want %0d", state, S_FETCH); end
        checks++; if (memwrite_cycles != 4) begin errors++; $display("FAIL sw_memwrite_len: got %0d want 4", memwrite_cycles); end
    endtask

    task automatic test_cpi();
        logic [5:0] ops[6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};
        int n;
        do_reset();
        drive_cycle(1'b1, 6'd0);
        foreach (ops[i]) begin
            if (ops[i] == 6'd8 && !addi_enabled()) continue;
            n = 0;
            do begin drive_cycle(1'b1, ops[i]); n++; end while (state !== S_FETCH && n < 50);
            checks++; if (n != cpi(ops[i])) begin errors++; $display("FAIL cpi op%0d: got %0d want %0d", ops[i], n, cpi(ops[i])); end
        end
    endtask

    task automatic test_random();
        logic [5:0] legal[6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};
        logic [10:0] e;
        logic [5:0] op;
        do_reset();
        repeat (30) begin
            op = legal[$urandom_range(0, addi_enabled() ? 5 : 4)];
            plan_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_cycle(e[6], e[5:0]);
            checks++; if (state !== e[10:7]) begin errors++; $display("FAIL rand_state: got %0d want %0d", state, e[10:7]); end
            checks++; if (outs !== exp_outs(e[10:7], e[6])) begin errors++; $display("FAIL rand_outs st%0d: got %h want %h", e[10:7], outs, exp_outs(e[10:7], e[6])); end
        end
    endtask

    task automatic test_trap_and_addi();
        logic [10:0] e;
        logic [5:0] ops[2] = '{6'd63, 6'd8};
        foreach (ops[i]) begin
            do_reset();
            plan_instr(ops[i], 0, 0);
            if (exp_q[exp_q.size()-1][10:7] == S_TRAP) repeat (20) push_plain(S_TRAP, 6'($urandom));
            else plan_instr(6'd0, 0, 0);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                drive_cycle(e[6], e[5:0]);
                checks++; if (state !== e[10:7]) begin errors++; $display("FAIL trap%0d_state: got %0d want %0d", ops[i], state, e[10:7]); end
                checks++; if (outs !== exp_outs(e[10:7], e[6])) begin errors++; $display("FAIL trap%0d_outs st%0d: got %h want %h", ops[i], e[10:7], outs, exp_outs(e[10:7], e[6])); end
            end
        end
        // From TRAP (opcode 63 case) or ADDI, a reset pulse must clear and restart fetching.
        do_reset();
        plan_instr(6'd63, 0, 0);
        while (exp_q.size() > 0) begin e = exp_q.pop_front(); drive_cycle(e[6], e[5:0]); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (illegal !== 1'b0 || state !== S_IDLE) begin errors++; $display("FAIL trap_clear: got illegal=%b state=%0d want 0/0", illegal, state); end
        @(negedge clk);
        reset_n = 1'b1;
        drive_cycle(1'b1, 6'd0);
        checks++; if (state !== S_FETCH) begin errors++; $display("FAIL trap_refetch: got %0d want %0d", state, S_FETCH); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive_cycle(1'b1, 6'd5);
        drive_cycle(1'b1, 6'd35);
        drive_cycle(1'b1, 6'd35);
        drive_cycle(1'b0, 6'd35);
        drive_cycle(1'b0, 6'd35);
        checks++; if (state !== S_MR || MemRead !== 1'b1) begin errors++; $display("FAIL stall_pre: got state=%0d MemRead=%b want 4/1", state, MemRead); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (state !== S_IDLE || MemRead !== 1'b0) begin errors++; $display("FAIL stall_reset: got state=%0d MemRead=%b want 0/0", state, MemRead); end
        checks++; if (outs !== '0) begin errors++; $display("FAIL stall_reset_outs: got %h want 0", outs); end
        @(negedge clk);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL stall_idle: got %0d want %0d", state, S_IDLE); end
        drive_cycle(1'b1, 6'd0);
        checks++; if (state !== S_FETCH) begin errors++; $display("FAIL stall_refetch: got %0d want %0d", state, S_FETCH); end
    endtask

    initial begin
        reset_n = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'd0;
        test_reset();
        test_lw();
        test_rtype_branch_jump();
        test_sw_stall();
        test_cpi();
        test_random();
        test_trap_and_addi();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It drives every datapath enable and mux select. It is also the producer of the 2-bit `ALUOp` consumed by the ALU control decoder (00 add, 01 subtract, 10 decode `funct`). Memory accesses stall on a `mem_ready` handshake, and unsupported opcodes trap.

## Interface
- `STATE_W`, default 4: width of the state register and of the `state` debug port.
- `clk`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction[31:26] from the IR; stable from DECODE onward.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls.
- `ALUOp`  out  2  00 add, 01 sub, 10 funct-decoded.
- `ALUSrcB`  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `illegal`  out  1  sticky trap flag.
- `state`  out  STATE_W  current state encoding.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=15. Codes 13–14 are unused and go to TRAP.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0. Next state is FETCH unconditionally.
- FETCH:
  - Static outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal `mem_ready`.
  - Hold while `mem_ready`=0; go to DECODE on `mem_ready`=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 0 (R-type) → EXECUTE
  - 35 (lw), 43 (sw) → MEM_ADDR
  - 4 (beq) → BRANCH
  - 2 (j) → JUMP
  - 8 (addi) → ADDI_EXEC
  - other → TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Hold until `mem_ready`, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until `mem_ready`, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- TRAP:
  - All datapath outputs 0; `illegal`=1.
  - Stays in TRAP until reset.
  - Used for illegal opcodes and unused state codes.
- `opcode` is sampled only in DECODE and MEM_ADDR. Changes in other states are ignored.

## Timing
- Reset:
  - On `reset_n` low, the state goes to IDLE immediately (asynchronous) and all outputs read 0, including `illegal`.
  - Applies mid-instruction, including during a memory stall. The pending access is abandoned.
  - First FETCH occurs one cycle after reset release.
- Outputs other than IRWrite/PCWrite in FETCH are pure functions of the state register, valid for the whole cycle.
- Cycles per instruction with `mem_ready` held at 1:

  | Instruction | Cycles |
  |---|---|
  | R-type | 4 |
  | lw | 5 |
  | sw | 4 |
  | beq | 3 |
  | j | 3 |
  | addi | 4 |

- Each cycle `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. No strobe repeats on exit.
- `mem_ready` is ignored in all other states.

## Configuration
- `CTRL_ADDI_EN`:
  - Defined: opcode 8 decodes to ADDI_EXEC→ADDI_WB as above.
  - Undefined: ADDI_EXEC/ADDI_WB are not compiled in, opcode 8 goes to TRAP, and codes 11–12 are treated as unused.

## Test plan
- Reset then lw (opcode 35), `mem_ready`=1: state sequence 0,1,2,3,4,5,1. MemtoReg=RegWrite=1 only in state 5. Five cycles from first FETCH to next FETCH.
- R-type (opcode 0): ALUOp=10 exactly in EXECUTE; RegWrite with RegDst=1 in R_WB; back to FETCH after 4 cycles.
- beq (opcode 4): ALUOp=01, PCWriteCond=1, PCSource=01 in BRANCH. j (opcode 2): PCWrite=1, PCSource=10.
- sw with `mem_ready` low 3 cycles in MEM_WRITE: MemWrite=1 for 4 cycles, then FETCH. Total 7 cycles. IRWrite=0 until `mem_ready` rises in FETCH.
- Opcode 63: DECODE→TRAP, `illegal`=1 and held for 20 cycles. `reset_n` pulse clears it; FETCH resumes. Opcode 8 with and without `CTRL_ADDI_EN`: ADDI path vs TRAP.
- Assert `reset_n` low during a MEM_READ stall: `state`=0 and MemRead=0 in the same cycle, before the next edge.
